// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: 2-flop sync + per-line debounce + detent-tracking FSM.
// Latency: raw edge to rot_event is DEBOUNCE_CYCLES+3 cycles; no backpressure, outputs are registered pulses.
module rotary_quad_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ROT_A,
  input  logic ROT_B,
  output logic rot_event,
  output logic rot_dir,
  output logic rot_err
);

  typedef enum logic [2:0] {
    IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC
  } state_t;

  // Bit 1 carries phase A, bit 0 phase B.
  logic [1:0]       sync1, sync2, filt, prev;
  logic [CNT_W-1:0] cnt [2];
  state_t           state, state_nxt;
  logic             event_nxt, dir_nxt, err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {ROT_A, ROT_B};
      sync2 <= sync1;
    end
  end

  // filt flips only after the line has disagreed with it on DEBOUNCE_CYCLES+1
  // consecutive edges, giving the k+2+DEBOUNCE_CYCLES raw-to-filt latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    event_nxt = 1'b0;
    dir_nxt   = rot_dir;
    err_nxt   = 1'b0;
    if (filt != prev) begin
      if (state == RESYNC) begin
        if (filt == 2'b11) state_nxt = IDLE;
      end else if (filt == ~prev) begin
        err_nxt   = 1'b1;
        state_nxt = RESYNC;
      end else begin
        // Single-bit steps only reach here, so each state sees exactly two neighbours.
        case (state)
          IDLE: begin
            if (filt == 2'b01)      state_nxt = CW1;
            else if (filt == 2'b10) state_nxt = CCW1;
          end
          CW1:  state_nxt = (filt == 2'b00) ? CW2  : IDLE;
          CW2:  state_nxt = (filt == 2'b10) ? CW3  : CW1;
          CW3: begin
            if (filt == 2'b11) begin
              state_nxt = IDLE;
              event_nxt = 1'b1;
              dir_nxt   = 1'b1;
            end else begin
              state_nxt = CW2;
            end
          end
          CCW1: state_nxt = (filt == 2'b00) ? CCW2 : IDLE;
          CCW2: state_nxt = (filt == 2'b01) ? CCW3 : CCW1;
          CCW3: begin
            if (filt == 2'b11) begin
              state_nxt = IDLE;
              event_nxt = 1'b1;
              dir_nxt   = 1'b0;
            end else begin
              state_nxt = CCW2;
            end
          end
          default: state_nxt = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= 2'b11;
      rot_event <= 1'b0;
      rot_dir   <= 1'b0;
      rot_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= filt;
      rot_event <= event_nxt;
      rot_dir   <= dir_nxt;
      rot_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Bench for rotary_quad_decoder: random hold times and glitches against a window/position reference model.
module tb_rotary_quad_decoder;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ROT_A = 1'b1;
  logic ROT_B = 1'b1;
  logic rot_event, rot_dir, rot_err;

  always #5 clk = ~clk;

  rotary_quad_decoder #(.DEBOUNCE_CYCLES(DB), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ROT_A(ROT_A), .ROT_B(ROT_B),
    .rot_event(rot_event), .rot_dir(rot_dir), .rot_err(rot_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: raw history per line, filtered pair, detent position.
  bit         ha[$], hb[$];
  logic [1:0] m_filt, m_prev;
  int         m_pos, m_nev;
  bit         m_resync;
  logic       m_ev, m_dir, m_err;

  // Observation tallies gathered by drive().
  int n_ev, n_cw, n_err, n_both, n_mis, ev_cyc, mis_cyc;
  logic [2:0] mis_got, mis_exp;

  function automatic int phase(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b01:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void model_reset();
    ha.delete();
    hb.delete();
    for (int i = 0; i < DB + 3; i++) begin
      ha.push_back(1'b1);
      hb.push_back(1'b1);
    end
    m_filt = 2'b11; m_prev = 2'b11; m_pos = 0; m_resync = 0;
    m_ev = 0; m_dir = 0; m_err = 0;
  endfunction

  function automatic void model_edge(input bit a, input bit b);
    bit all_a, all_b;
    int d;
    m_ev = 0;
    m_err = 0;
    if (m_filt != m_prev) begin
      if (m_resync) begin
        if (m_filt == 2'b11) begin m_resync = 0; m_pos = 0; end
      end else if ((m_filt ^ m_prev) == 2'b11) begin
        m_err = 1; m_resync = 1;
      end else begin
        d = (phase(m_filt) - phase(m_prev) + 4) % 4;
        m_pos += (d == 1) ? 1 : -1;
        if (m_filt == 2'b11) begin
          if (m_pos == 4)       begin m_ev = 1; m_dir = 1; m_nev++; end
          else if (m_pos == -4) begin m_ev = 1; m_dir = 0; m_nev++; end
          m_pos = 0;
        end
      end
    end
    m_prev = m_filt;
    ha.push_back(a); void'(ha.pop_front());
    hb.push_back(b); void'(hb.pop_front());
    // A level passes once the raw line, seen two edges late, held it for DB+1 samples.
    all_a = 1; all_b = 1;
    for (int i = 1; i <= DB; i++) begin
      if (ha[i] != ha[0]) all_a = 0;
      if (hb[i] != hb[0]) all_b = 0;
    end
    if (all_a) m_filt[1] = ha[0];
    if (all_b) m_filt[0] = hb[0];
  endfunction

  function automatic void clr();
    n_ev = 0; n_cw = 0; n_err = 0; n_both = 0; n_mis = 0; ev_cyc = -1; mis_cyc = -1;
    mis_got = '0; mis_exp = '0;
  endfunction

  task automatic drive(input logic [1:0] ab, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ROT_A = ab[1];
      ROT_B = ab[0];
      @(posedge clk);
      cyc++;
      model_edge(ab[1], ab[0]);
      #1;
      if (rot_event) begin n_ev++; ev_cyc = cyc; if (rot_dir) n_cw++; end
      if (rot_err) n_err++;
      if (rot_event && rot_err) n_both++;
      if ({rot_event, rot_dir, rot_err} !== {m_ev, m_dir, m_err}) begin
        if (n_mis == 0) begin
          mis_cyc = cyc; mis_got = {rot_event, rot_dir, rot_err}; mis_exp = {m_ev, m_dir, m_err};
        end
        n_mis++;
      end
    end
  endtask

  task automatic cw_detent(input int h);
    drive(2'b01, h); drive(2'b00, h); drive(2'b10, h); drive(2'b11, 10);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({rot_event, rot_dir, rot_err} !== 3'b000) begin
      bad++; $display("FAIL reset_outputs got=%b want=000", {rot_event, rot_dir, rot_err});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    clr();
    drive(2'b11, 50);
    total++;
    if (n_ev != 0 || n_err != 0 || n_mis != 0) begin
      bad++; $display("FAIL idle_quiet events=%0d errs=%0d model_diffs=%0d want 0/0/0", n_ev, n_err, n_mis);
    end
  endtask

  task automatic test_cw();
    int k;
    clr();
    drive(2'b01, 10); drive(2'b00, 10); drive(2'b10, 10);
    k = cyc + 1;
    drive(2'b11, 10);
    total++;
    if (n_ev != 1 || n_cw != 1) begin
      bad++; $display("FAIL cw_event events=%0d cw=%0d want 1/1", n_ev, n_cw);
    end
    total++;
    if (ev_cyc != k + 7) begin
      bad++; $display("FAIL cw_latency event_edge=%0d want=%0d", ev_cyc, k + 7);
    end
    total++;
    if (n_err != 0 || n_mis != 0) begin
      bad++; $display("FAIL cw_model errs=%0d diffs=%0d at cyc %0d got=%b exp=%b", n_err, n_mis, mis_cyc, mis_got, mis_exp);
    end
  endtask

  task automatic test_ccw_then_cw();
    clr();
    drive(2'b10, $urandom_range(6, 12)); drive(2'b00, $urandom_range(6, 12));
    drive(2'b01, $urandom_range(6, 12)); drive(2'b11, 10);
    total++;
    if (n_ev != 1 || n_cw != 0 || rot_dir !== 1'b0) begin
      bad++; $display("FAIL ccw_event events=%0d cw=%0d dir=%b want 1/0/0", n_ev, n_cw, rot_dir);
    end
    clr();
    for (int i = 0; i < 3; i++) cw_detent($urandom_range(6, 12));
    total++;
    if (n_ev != 3 || n_cw != 3) begin
      bad++; $display("FAIL cw_x3 events=%0d cw=%0d want 3/3", n_ev, n_cw);
    end
    total++;
    if (n_mis != 0 || n_err != 0) begin
      bad++; $display("FAIL ccw_cw_model diffs=%0d errs=%0d at cyc %0d got=%b exp=%b", n_mis, n_err, mis_cyc, mis_got, mis_exp);
    end
  endtask

  task automatic test_glitch_partial();
    clr();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, $urandom_range(5, 10));
      drive(2'b01, 3);
    end
    drive(2'b11, 12);
    total++;
    if (n_ev != 0 || n_err != 0 || n_mis != 0) begin
      bad++; $display("FAIL glitch events=%0d errs=%0d diffs=%0d want 0/0/0", n_ev, n_err, n_mis);
    end
    clr();
    drive(2'b01, 10); drive(2'b00, 10); drive(2'b01, 10); drive(2'b11, 10);
    total++;
    if (n_ev != 0 || n_err != 0 || n_mis != 0) begin
      bad++; $display("FAIL partial events=%0d errs=%0d diffs=%0d want 0/0/0", n_ev, n_err, n_mis);
    end
  endtask

  task automatic test_error();
    clr();
    drive(2'b00, 10); drive(2'b10, 10);
    total++;
    if (n_err != 1 || n_ev != 0) begin
      bad++; $display("FAIL err_pulse errs=%0d events=%0d want 1/0", n_err, n_ev);
    end
    drive(2'b11, 10);
    clr();
    cw_detent(10);
    total++;
    if (n_ev != 1 || n_cw != 1 || n_err != 0 || n_mis != 0) begin
      bad++; $display("FAIL err_recover events=%0d cw=%0d errs=%0d diffs=%0d want 1/1/0/0", n_ev, n_cw, n_err, n_mis);
    end
  endtask

  task automatic test_reset_mid();
    int zero_bad;
    clr();
    drive(2'b01, 10); drive(2'b00, 10);
    @(negedge clk);
    rst_n = 1'b0;
    zero_bad = 0;
    #1;
    if ({rot_event, rot_dir, rot_err} !== 3'b000) zero_bad++;
    repeat (3) begin
      @(posedge clk); #1;
      if ({rot_event, rot_dir, rot_err} !== 3'b000) zero_bad++;
    end
    total++;
    if (zero_bad != 0) begin
      bad++; $display("FAIL reset_mid_outputs nonzero_samples=%0d want 0", zero_bad);
    end
    rst_n = 1'b1;
    model_reset();
    drive(2'b00, 10); drive(2'b10, 10); drive(2'b11, 10);
    total++;
    if (n_ev != 0 || n_mis != 0) begin
      bad++; $display("FAIL reset_mid_event events=%0d diffs=%0d at cyc %0d got=%b exp=%b", n_ev, n_mis, mis_cyc, mis_got, mis_exp);
    end
  endtask

  task automatic test_random_walk();
    logic [1:0] gray [4];
    logic [1:0] cur;
    int p, r, start_nev;
    gray[0] = 2'b11; gray[1] = 2'b01; gray[2] = 2'b00; gray[3] = 2'b10;
    clr();
    start_nev = m_nev;
    p = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        p = (r < 4) ? (p + 1) % 4 : (p + 3) % 4;
        drive(gray[p], $urandom_range(6, 10));
      end else begin
        cur = gray[p];
        cur[$urandom_range(0, 1)] ^= 1'b1;
        drive(cur, $urandom_range(1, DB));
        drive(gray[p], $urandom_range(6, 10));
      end
    end
    drive(2'b11, 12);
    total++;
    if (n_mis != 0) begin
      bad++; $display("FAIL random_model diffs=%0d first at cyc %0d got=%b exp=%b", n_mis, mis_cyc, mis_got, mis_exp);
    end
    total++;
    if (n_ev != m_nev - start_nev || n_both != 0) begin
      bad++; $display("FAIL random_counts events=%0d want=%0d both_high=%0d", n_ev, m_nev - start_nev, n_both);
    end
  endtask

  initial begin
    model_reset();
    m_nev = 0;
    test_reset();
    test_cw();
    test_ccw_then_cw();
    test_glitch_partial();
    test_error();
    test_reset_mid();
    test_random_walk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
